// File: rtl/morse_player_if.sv
// Digit handoff between the upstream sequencer (master) and the Morse keyer (slave).
interface morse_player_if;
  logic       start;
  logic [4:0] code;
  logic       tone;
  logic       busy;
  logic       done;
  logic [2:0] sym_idx;

  modport master (output start, code, input tone, busy, done, sym_idx);
  modport slave  (input start, code, output tone, busy, done, sym_idx);
endinterface

// File: rtl/morse_player.sv
// Morse keyer: latches a 5-symbol code (bit 4 first, 1 = dot) and keys it out
// on tone with 1/3-unit marks, 1-unit gaps and a 3-unit tail, then pulses done.
module morse_player #(
  parameter int UNIT_CYCLES = 12_500_000
) (
  input logic           clk,
  input logic           reset,
  morse_player_if.slave bus
);
  localparam int CW = $clog2(3 * UNIT_CYCLES + 1);
  localparam logic [CW-1:0] ONE_END   = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] THREE_END = CW'(3 * UNIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MARK, GAP, TAIL} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    sh_q, sh_d;
  logic [2:0]    idx_q, idx_d;
  logic          tone_q, tone_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    sh_d    = sh_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.start) begin
          state_d = MARK;
          sh_d    = bus.code;
          idx_d   = 3'd0;
        end
      end
      MARK: begin
        // current symbol is always the MSB of the shift register
        if (cnt_q == (sh_q[4] ? ONE_END : THREE_END)) begin
          cnt_d   = '0;
          state_d = (idx_q == 3'd4) ? TAIL : GAP;
        end
      end
      GAP: begin
        if (cnt_q == ONE_END) begin
          cnt_d   = '0;
          state_d = MARK;
          sh_d    = {sh_q[3:0], 1'b0};
          idx_d   = idx_q + 3'd1;
        end
      end
      TAIL: begin
        if (cnt_q == THREE_END) begin
          cnt_d   = '0;
          state_d = IDLE;
          idx_d   = 3'd0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // outputs registered from the next state so they line up with it
    tone_d = (state_d == MARK);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      idx_q   <= '0;
      tone_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      tone_q  <= tone_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.tone    = tone_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.sym_idx = idx_q;
endmodule

// File: tb/tb_morse_player.sv
// Directed bench for morse_player at UNIT_CYCLES = 4, 2 and 1; tone patterns are
// written per Morse unit and expanded to cycles.
module tb_morse_player;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  morse_player_if if0 ();
  morse_player_if if1 ();
  morse_player_if if2 ();

  morse_player #(.UNIT_CYCLES(4)) d0 (.clk(clk), .reset(reset), .bus(if0.slave));
  morse_player #(.UNIT_CYCLES(2)) d1 (.clk(clk), .reset(reset), .bus(if1.slave));
  morse_player #(.UNIT_CYCLES(1)) d2 (.clk(clk), .reset(reset), .bus(if2.slave));

  logic       st [3];
  logic [4:0] cd [3];
  logic       tn [3], bz [3], dn [3];
  logic [2:0] ix [3];

  assign if0.start = st[0]; assign if0.code = cd[0];
  assign if1.start = st[1]; assign if1.code = cd[1];
  assign if2.start = st[2]; assign if2.code = cd[2];
  assign tn[0] = if0.tone; assign bz[0] = if0.busy; assign dn[0] = if0.done; assign ix[0] = if0.sym_idx;
  assign tn[1] = if1.tone; assign bz[1] = if1.busy; assign dn[1] = if1.done; assign ix[1] = if1.sym_idx;
  assign tn[2] = if2.tone; assign bz[2] = if2.busy; assign dn[2] = if2.done; assign ix[2] = if2.sym_idx;

  int uc [3] = '{4, 2, 1};
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         sel;
    logic [4:0] code;
    string      pat;
    int         busy_cyc;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string nm, input int cyc, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Plays one digit; checks every busy cycle, then the done cycle.
  task automatic play(input int sel, input logic [4:0] c, input string pat, input int n,
                      input bit hold, input bit noisy);
    int   u;
    int   idx;
    logic et;
    u   = uc[sel];
    idx = 0;
    @(negedge clk);
    st[sel] = 1'b1;
    cd[sel] = c;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!hold) st[sel] = 1'b0;
      if (noisy) begin
        cd[sel] = 5'($urandom);
        st[sel] = (i % 7 == 3);
      end
      et = (pat[i/u] == "1");
      if (i > 0 && i % u == 0 && et && pat[i/u-1] == "0") idx++;
      chk("tone", i, {7'd0, tn[sel]}, {7'd0, et});
      chk("busy", i, {7'd0, bz[sel]}, 8'd1);
      chk("done_low", i, {7'd0, dn[sel]}, 8'd0);
      if (et) chk("sym_idx", i, {5'd0, ix[sel]}, 8'(idx));
    end
    @(negedge clk);
    if (!hold) st[sel] = 1'b0;
    chk("done_pulse", n, {7'd0, dn[sel]}, 8'd1);
    chk("busy_end", n, {7'd0, bz[sel]}, 8'd0);
    chk("tone_end", n, {7'd0, tn[sel]}, 8'd0);
    chk("sym_idx_end", n, {5'd0, ix[sel]}, 8'd0);
    if (!hold) begin
      @(negedge clk);
      chk("done_one_cycle", n + 1, {7'd0, dn[sel]}, 8'd0);
      chk("busy_idle", n + 1, {7'd0, bz[sel]}, 8'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    string pat2;
    tbl[0] = '{0, 5'b10000, "10111011101110111000", 80};
    tbl[1] = '{0, 5'b11111, "101010101000", 48};
    tbl[2] = '{1, 5'b00000, "1110111011101110111000", 44};
    tbl[3] = '{2, 5'b01010, "111010111010111000", 18};
    tbl[4] = '{1, 5'b01111, "11101010101000", 28};

    // reset holds everything quiet even with start asserted
    reset = 1'b1;
    for (int s = 0; s < 3; s++) begin st[s] = 1'b1; cd[s] = 5'b11111; end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
        chk("rst_tone", c, {7'd0, tn[s]}, 8'd0);
        chk("rst_busy", c, {7'd0, bz[s]}, 8'd0);
        chk("rst_done", c, {7'd0, dn[s]}, 8'd0);
        chk("rst_sym_idx", c, {5'd0, ix[s]}, 8'd0);
      end
    end
    reset = 1'b0;
    for (int s = 0; s < 3; s++) st[s] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
        chk("post_rst_busy", c, {7'd0, bz[s]}, 8'd0);
        chk("post_rst_tone", c, {7'd0, tn[s]}, 8'd0);
      end
    end

    foreach (tbl[k]) play(tbl[k].sel, tbl[k].code, tbl[k].pat, tbl[k].busy_cyc, 1'b0, 1'b0);

    // start pulses and code churn during playback must not disturb it
    play(1, 5'b00000, "1110111011101110111000", 44, 1'b0, 1'b1);

    // back-to-back with start held high, then reset in the third mark
    play(0, 5'b01111, "11101010101000", 56, 1'b1, 1'b0);
    cd[0] = 5'b00111;
    pat2 = "1110111010101000";
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      chk("b2b_tone", i, {7'd0, tn[0]}, {7'd0, pat2[i/4] == "1"});
      chk("b2b_busy", i, {7'd0, bz[0]}, 8'd1);
      if (i == 33) begin
        reset = 1'b1;
        st[0] = 1'b0;
      end
    end
    @(negedge clk);
    chk("abort_tone", 0, {7'd0, tn[0]}, 8'd0);
    chk("abort_busy", 0, {7'd0, bz[0]}, 8'd0);
    chk("abort_done", 0, {7'd0, dn[0]}, 8'd0);
    chk("abort_sym_idx", 0, {5'd0, ix[0]}, 8'd0);
    reset = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      chk("abort_no_done", c, {7'd0, dn[0]}, 8'd0);
      chk("abort_idle", c, {7'd0, bz[0]}, 8'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/morse_player.md
# morse_player

Sequential Morse keyer sitting directly downstream of the BCD-to-Morse encoder. It latches one 5-symbol digit code on a start strobe and plays it out on a single tone line (LED/buzzer) with standard Morse timing. The timing is derived from a clock-cycle prescaler. A one-cycle `done` pulse tells the digit sequencer upstream that the next digit may be issued.

## Interface

- `UNIT_CYCLES`, default 12_500_000: clock cycles per Morse time unit (250 ms at 50 MHz); legal range ≥ 1.
- `clk`  input  1  rising-edge system clock.
- `reset`  input  1  reset, synchronous, active-high.
- `start`  input  1  request to play `code`; sampled only in IDLE.
- `code`  input  5  encoder output; bit 4 transmitted first; 1 = dot, 0 = dash.
- `tone`  output  1  registered key output, 1 = mark (sound/light on).
- `busy`  output  1  registered, 1 from the cycle after an accepted start until playback ends.
- `done`  output  1  registered one-cycle pulse marking end of playback.
- `sym_idx`  output  3  registered index of the symbol being played (0..4, 0 = code bit 4); 0 when idle.

## Operation

- States:
  - IDLE: tone=0, busy=0.
  - MARK: tone=1.
  - GAP: inter-symbol space, tone=0.
  - TAIL: inter-character space, tone=0.
- IDLE → MARK when `start`=1. `code` is latched into an internal shift register in the same edge; `sym_idx`←0.
- In IDLE with `start`=0, the state stays IDLE.
- `start` in any state other than IDLE is ignored. `code` changes after acceptance have no effect.
- MARK length is 1 unit for a dot and 3 units for a dash, judged by the current symbol bit.
- At the end of MARK:
  - If `sym_idx` < 4, go to GAP.
  - If `sym_idx` = 4, go to TAIL.
- GAP length is 1 unit. At its end, `sym_idx` increments, the shift register advances, and the state goes to MARK.
- TAIL length is 3 units. At its end, go to IDLE with `done`=1 for exactly that first IDLE cycle.
- A `start` present during the `done` cycle is accepted normally (back-to-back digits, no extra gap).
- Code 00000 is a valid digit "0" and is played as five dashes. The block does not filter it; the upstream sequencer simply must not strobe `start` for invalid or reset-state codes.
- Cycle counter:
  - Counts 0 .. (n·UNIT_CYCLES − 1) for an n-unit interval, then reloads to 0 on a state change.
  - Width is ceil(log2(3·UNIT_CYCLES + 1)).
  - The counter never wraps inside an interval.
- Reset:
  - Values: state=IDLE, tone=0, busy=0, done=0, sym_idx=0, counter=0, shift register=0.
  - Reset has priority over `start` in the same cycle.
  - Reset mid-playback aborts immediately; no `done` pulse is produced for the aborted digit.

## Timing

- Accept edge: `start`=1 in IDLE at edge E. From cycle E+1, `tone`=1, `busy`=1, `sym_idx`=0.
- Exact interval lengths:
  - Dot mark: tone high for UNIT_CYCLES consecutive cycles.
  - Dash mark: tone high for 3·UNIT_CYCLES consecutive cycles.
  - GAP: tone low for UNIT_CYCLES cycles.
  - TAIL: tone low for 3·UNIT_CYCLES cycles.
- Total busy duration for a code with k dots: (22 − 2k)·UNIT_CYCLES cycles. Examples: digit 0 takes 22 units, digit 5 (11111) takes 12 units.
- `done` rises in the first cycle with `busy`=0 and lasts 1 cycle.
- `sym_idx` updates on the same edge that starts the next MARK.
- No combinational path from inputs to outputs.

## Test plan

- **Reset values:** assert `reset` for 3 cycles with `start`=1, `code`=11111 → tone=0, busy=0, done=0, sym_idx=0 throughout; no playback after release until a new `start`.
- **Digit 1, all intervals:** UNIT_CYCLES=4, `code`=10000 (".----"), one-cycle `start` → tone high 4, low 4, then four groups of (high 12, low 4/4/4/12); busy high 80 cycles; done pulse on cycle 81 after accept.
- **Digit 5, fastest case:** UNIT_CYCLES=4, `code`=11111 → five 4-cycle marks separated by 4-cycle gaps, then 12-cycle tail; busy high 48 cycles; `sym_idx` steps 0→4.
- **Ignored inputs while busy:** during playback of 00000 (UNIT_CYCLES=2), pulse `start` with `code`=11111 at several points and toggle `code` → output unchanged (five 6-cycle marks); busy high 44 cycles.
- **Back-to-back and reset abort:** `start` held high continuously with `code`=01111 then 00111 switched at the `done` cycle → second digit's first mark begins the cycle after `done`. A `reset` pulse in its third mark forces tone=0, busy=0 next cycle, with no `done`.
- **UNIT_CYCLES=1 corner:** `code`=01010 → tone sequence 111 0 1 0 111 0 1 0 111 000; busy 18 cycles; done on cycle 19.
